time_set_controller: RTL and testbench



---
 rtl/time_set_controller_if.sv | 28 ++
 rtl/time_set_controller.sv | 114 +++++++++++
 tb/tb_time_set_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: tick, button and display signals of the time-set controller
//    SecTick    - one-cycle pulse per second
//    ModeBtn    - mode button level (synchronized, debounced)
//    IncBtn     - increment button level (synchronized, debounced)
//    hourten/hourone/mintens/minones - BCD time digits
//    DigitBlank - per-digit blank mask {hourten, hourone, mintens, minones}
//    Mode       - 00 RUN, 01 SET_HOUR, 10 SET_MIN
//    PM         - afternoon flag (12-hour build only)
interface time_set_controller_if;
   logic       SecTick;
   logic       ModeBtn;
   logic       IncBtn;
   logic [3:0] hourten;
   logic [3:0] hourone;
   logic [3:0] mintens;
   logic [3:0] minones;
   logic [3:0] DigitBlank;
   logic [1:0] Mode;
   logic       PM;
   modport master (
      output SecTick, ModeBtn, IncBtn,
      input  hourten, hourone, mintens, minones, DigitBlank, Mode, PM
   );
   modport slave (
      input  SecTick, ModeBtn, IncBtn,
      output hourten, hourone, mintens, minones, DigitBlank, Mode, PM
   );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller: BCD clock with a two-button hour/minute set FSM and a blink mask
//    Clock - system clock, rising edge
//    Reset - synchronous, active-high
//    bus   - time_set_controller_if.slave: SecTick/ModeBtn/IncBtn in; digits, DigitBlank, Mode, PM out
//    Build option: define TWELVE_HOUR_EN for a 12..11 hour range with a PM flag.
module time_set_controller (
   input logic Clock,
   input logic Reset,
   time_set_controller_if.slave bus
);
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10
   } state_t;

`ifdef TWELVE_HOUR_EN
   localparam logic [7:0] HOUR_TOP = 8'h12;
   localparam logic [7:0] HOUR_LOW = 8'h01;
   localparam logic [7:0] HOUR_RST = 8'h12;
`else
   localparam logic [7:0] HOUR_TOP = 8'h23;
   localparam logic [7:0] HOUR_LOW = 8'h00;
   localparam logic [7:0] HOUR_RST = 8'h00;
`endif

   state_t     state, state_nxt;
   logic [5:0] sec, sec_nxt;
   logic [7:0] hour, hour_nxt;
   logic [7:0] min, min_nxt;
   logic       phase, phase_nxt;
   logic       pm, pm_nxt;
   logic [3:0] blank, blank_nxt;
   logic       mode_prev, inc_prev;
   logic       mode_press, inc_press;
   logic       hour_step, min_step;

   // BCD pair increment: wraps top -> low, ones digit carries into tens at 9
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top,
                                          input logic [7:0] low);
      bcd_inc = (v == top) ? low :
                (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   // prev registers reset to 1 so a button held through reset is not a press;
   // mode has priority, so a simultaneous inc press is dropped
   assign mode_press = bus.ModeBtn & ~mode_prev;
   assign inc_press  = bus.IncBtn & ~inc_prev & ~mode_press;

   always_comb begin
      state_nxt = state;
      sec_nxt   = sec;
      hour_step = 1'b0;
      min_step  = 1'b0;
      if (mode_press)
         state_nxt = (state == RUN) ? SET_HOUR : (state == SET_HOUR) ? SET_MIN : RUN;
      if (state == RUN && bus.SecTick) begin
         sec_nxt   = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
         min_step  = (sec == 6'd59);
         hour_step = (sec == 6'd59) && (min == 8'h59);
      end
      if (state == SET_HOUR)
         hour_step = inc_press;
      if (state == SET_MIN) begin
         min_step = inc_press;
         // leaving SET_MIN restarts the minute cleanly; a coincident tick is discarded
         if (mode_press)
            sec_nxt = 6'd0;
      end
      min_nxt   = min_step ? bcd_inc(min, 8'h59, 8'h00) : min;
      hour_nxt  = hour_step ? bcd_inc(hour, HOUR_TOP, HOUR_LOW) : hour;
`ifdef TWELVE_HOUR_EN
      pm_nxt    = pm ^ (hour_step && hour == 8'h11);
`else
      pm_nxt    = 1'b0;
`endif
      // entering a set state restarts the blink with digits visible
      phase_nxt = (mode_press && state_nxt != RUN) ? 1'b0 : phase ^ bus.SecTick;
      blank_nxt = (state_nxt == SET_HOUR) ? {phase_nxt, phase_nxt, 2'b00} :
                  (state_nxt == SET_MIN)  ? {2'b00, phase_nxt, phase_nxt} : 4'b0000;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= RUN;
         sec       <= 6'd0;
         hour      <= HOUR_RST;
         min       <= 8'h00;
         phase     <= 1'b0;
         pm        <= 1'b0;
         blank     <= 4'b0000;
         mode_prev <= 1'b1;
         inc_prev  <= 1'b1;
      end else begin
         state     <= state_nxt;
         sec       <= sec_nxt;
         hour      <= hour_nxt;
         min       <= min_nxt;
         phase     <= phase_nxt;
         pm        <= pm_nxt;
         blank     <= blank_nxt;
         mode_prev <= bus.ModeBtn;
         inc_prev  <= bus.IncBtn;
      end
   end

   assign bus.hourten    = hour[7:4];
   assign bus.hourone    = hour[3:0];
   assign bus.mintens    = min[7:4];
   assign bus.minones    = min[3:0];
   assign bus.DigitBlank = blank;
   assign bus.Mode       = state;
   assign bus.PM         = pm;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: scoreboard bench with a seconds/minutes/hours reference model
module tb_time_set_controller;
   logic Clock = 1'b0;
   logic Reset = 1'b1;
   time_set_controller_if bus ();

   time_set_controller dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  blank;
      logic [1:0]  mode;
      logic        pm;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   int   m_h, m_m, m_s, m_md;
   logic m_ph, m_pm, m_mprev, m_iprev;

   task automatic hour_up();
`ifdef TWELVE_HOUR_EN
      m_h = m_h % 12 + 1;
      if (m_h == 12) m_pm = ~m_pm;
`else
      m_h = (m_h + 1) % 24;
`endif
   endtask

   task automatic model(input logic r, input logic s, input logic m, input logic i);
      logic mp, ip;
      int nmd;
      if (r) begin
`ifdef TWELVE_HOUR_EN
         m_h = 12;
`else
         m_h = 0;
`endif
         m_m = 0; m_s = 0; m_md = 0; m_ph = 0; m_pm = 0; m_mprev = 1; m_iprev = 1;
      end else begin
         mp  = m && !m_mprev;
         ip  = i && !m_iprev && !mp;
         nmd = mp ? (m_md + 1) % 3 : m_md;
         if (m_md == 0 && s) begin
            m_s = m_s + 1;
            if (m_s == 60) begin
               m_s = 0;
               m_m = m_m + 1;
               if (m_m == 60) begin
                  m_m = 0;
                  hour_up();
               end
            end
         end else if (m_md == 1 && ip) begin
            hour_up();
         end else if (m_md == 2) begin
            if (mp) m_s = 0;
            else if (ip) m_m = (m_m + 1) % 60;
         end
         m_ph    = (mp && nmd != 0) ? 1'b0 : m_ph ^ s;
         m_md    = nmd;
         m_mprev = m;
         m_iprev = i;
      end
   endtask

   function automatic exp_t expected();
      exp_t e;
      e.digits = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10)};
      e.blank  = (m_md == 1) ? {m_ph, m_ph, 2'b00} : (m_md == 2) ? {2'b00, m_ph, m_ph} : 4'b0000;
      e.mode   = 2'(m_md);
      e.pm     = m_pm;
      return e;
   endfunction

   task automatic step(input logic r, input logic s, input logic m, input logic i);
      @(negedge Clock);
      Reset       = r;
      bus.SecTick = s;
      bus.ModeBtn = m;
      bus.IncBtn  = i;
      model(r, s, m, i);
      sb.push_back(expected());
   endtask

   task automatic press_mode(input logic s);
      step(0, s, 1, 0);
      step(0, 0, 0, 0);
   endtask

   task automatic press_inc(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 0, 0, 1);
         step(0, 0, 0, 0);
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge Clock) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("time", {bus.hourten, bus.hourone, bus.mintens, bus.minones}, e.digits);
         chk("blank", {12'h0, bus.DigitBlank}, {12'h0, e.blank});
         chk("mode", {14'h0, bus.Mode}, {14'h0, e.mode});
         chk("pm", {15'h0, bus.PM}, {15'h0, e.pm});
      end
   end

   initial begin
      bus.SecTick = 0;
      bus.ModeBtn = 0;
      bus.IncBtn  = 0;
      // reset with ModeBtn held: no transition until it is released and pressed again
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      // preset 23:59 (12h: 11:59) through the set modes
      press_mode(0);
`ifdef TWELVE_HOUR_EN
      press_inc(11);
`else
      press_inc(23);
`endif
      for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
      press_mode(0);
      press_inc(59);
      press_mode(0);
      for (int k = 0; k < 60; k++) step(0, 1, 0, 0);
      // hours to 05 then simultaneous mode+inc
      press_mode(1);
`ifdef TWELVE_HOUR_EN
      press_inc(5);
`else
      press_inc(5);
`endif
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      press_inc(58);
      press_inc(3);
      // return to RUN with a coincident tick, then a full minute
      press_mode(1);
      for (int k = 0; k < 62; k++) step(0, 1, 0, 0);
      // randomized traffic
      for (int k = 0; k < 4000; k++)
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      step(0, 0, 0, 0);
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge Clock);
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
